param_serializer: RTL

PARAM_SERIALIZER -- requirements
Module: param_serializer

---
 rtl/param_serializer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/param_serializer.sv
// param_serializer: parallel-to-serial shifter with framing strobes.
// A word is accepted on an in_valid/in_ready edge and streamed out one bit
// per cycle on a registered data_out, LSB or MSB first. Back-to-back words
// stream with no idle cycle when offered during the last bit of a frame.
// Optional feature macro: SER_PARITY_EN appends one even-parity bit to
// every frame (state PARITY); without it frames are exactly WIDTH bits.
module param_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             data_out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef SER_PARITY_EN
    PARITY = 2'd2,
`endif
    SHIFT  = 2'd1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic             data_q;
  logic             last_data;
  logic             last_bit;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             par_q;
`endif

  // Bit that leaves the word first in the selected order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with the just-emitted bit shifted out, zero filled.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign last_data = (state == SHIFT) && (cnt == LAST_DATA);
`ifdef SER_PARITY_EN
  assign last_bit  = (state == PARITY);
`else
  assign last_bit  = last_data;
`endif
  assign accept    = in_valid && in_ready;
  assign data_out  = data_q;
  assign busy      = out_valid;

  // State register; reset wins over any handshake at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a new word can start from IDLE or straight off the last bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_data) begin
`ifdef SER_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        state_nxt = accept ? SHIFT : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the registered state; in_ready is held low in reset.
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    if (!rst) in_ready = (state == IDLE) || last_bit;
    out_valid   = (state != IDLE);
    frame_start = (state == SHIFT) && (cnt == '0);
    frame_end   = last_bit;
  end

  // Shift register, bit counter and the registered serial bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      sreg   <= '0;
      data_q <= IDLE_LEVEL;
`ifdef SER_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else if (accept) begin
      cnt    <= '0;
      data_q <= first_bit(data_in);
      sreg   <= shift_word(data_in);
`ifdef SER_PARITY_EN
      par_q  <= ^data_in;
`endif
    end else if ((state == SHIFT) && !last_data) begin
      cnt    <= cnt + CW'(1);
      data_q <= first_bit(sreg);
      sreg   <= shift_word(sreg);
`ifdef SER_PARITY_EN
    end else if (last_data) begin
      cnt    <= cnt + CW'(1);
      data_q <= par_q;
      sreg   <= '0;
`endif
    end else begin
      cnt    <= '0;
      data_q <= IDLE_LEVEL;
      sreg   <= '0;
    end
  end

endmodule
